// File: rtl/dds_pkg.sv
// Shared widths, wave codes and sweep state encoding for the DDS front end.
// Optional ping-pong sweeping is enabled with DDS_SWEEP_PINGPONG_EN.
package dds_pkg;

    localparam int FWORD_W = 32;
    localparam int PWORD_W = 12;
    localparam int WAVE_W  = 3;

    localparam logic [WAVE_W-1:0] WAVE_SINE = 3'd0;
    localparam logic [WAVE_W-1:0] WAVE_SAWT = 3'd1;
    localparam logic [WAVE_W-1:0] WAVE_SQUA = 3'd2;
    localparam logic [WAVE_W-1:0] WAVE_TRIA = 3'd3;
    localparam logic [WAVE_W-1:0] WAVE_DIY  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/dds_step_calc.sv
// Next frequency word toward a target, clamped so the target is hit exactly.
// 33-bit arithmetic keeps sweeps near the top of the range from wrapping.
module dds_step_calc
    import dds_pkg::*;
(
    input  logic [FWORD_W-1:0] cur,
    input  logic [FWORD_W-1:0] step,
    input  logic [FWORD_W-1:0] target,
    input  logic               down,
    output logic [FWORD_W-1:0] next,
    output logic               at_target
);

    logic [FWORD_W:0] sum;
    logic [FWORD_W:0] lim;
    logic [FWORD_W:0] dif;

    always_comb begin
        sum = {1'b0, cur} + {1'b0, step};
        lim = {1'b0, target} + {1'b0, step};
        dif = {1'b0, cur} - {1'b0, step};
        next = target;
        if (down) begin
            if ({1'b0, cur} >= lim)
                next = dif[FWORD_W-1:0];
        end else begin
            if (sum < {1'b0, target})
                next = sum[FWORD_W-1:0];
        end
        // A zero step can never advance, so it counts as already there.
        at_target = (cur == target) || (step == '0);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving dds_gen Fword/Pword/wave_type_in.
// DDS_SWEEP_PINGPONG_EN: looped sweeps reverse at each endpoint.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int DWELL_W = 24
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_f_start,
    input  logic [31:0]        cfg_f_stop,
    input  logic [31:0]        cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [11:0]        cfg_pword,
    input  logic [2:0]         cfg_wave,
    input  logic               cfg_loop,
    input  logic               abort,
    output logic [31:0]        Fword,
    output logic [11:0]        Pword,
    output logic [2:0]         wave_type_out,
    output logic               busy,
    output logic               sweep_done
);

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    sweep_state_t state_q;
    sweep_state_t state_d;

    logic [FWORD_W-1:0] f_start_q;
    logic [FWORD_W-1:0] f_stop_q;
    logic [FWORD_W-1:0] step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               loop_q;
    logic               down_q;
    logic [FWORD_W-1:0] fword_q;
    logic [PWORD_W-1:0] pword_q;
    logic [WAVE_W-1:0]  wave_q;

    logic [FWORD_W-1:0] tgt;
    logic [FWORD_W-1:0] nxt;
    logic               at_tgt;
    logic               point_end;

    assign point_end = (cnt_q == '0);

`ifdef DDS_SWEEP_PINGPONG_EN
    logic [FWORD_W-1:0] tgt_q;
    logic [FWORD_W-1:0] rev_tgt;
    logic [FWORD_W-1:0] rev_nxt;
    logic               rev_at;

    assign tgt     = tgt_q;
    assign rev_tgt = (tgt_q == f_stop_q) ? f_start_q : f_stop_q;

    // Leaves the endpoint on the turn edge so each endpoint shows once.
    dds_step_calc u_rev (
        .cur       (fword_q),
        .step      (step_q),
        .target    (rev_tgt),
        .down      (~down_q),
        .next      (rev_nxt),
        .at_target (rev_at)
    );
`else
    assign tgt = f_stop_q;
`endif

    dds_step_calc u_fwd (
        .cur       (fword_q),
        .step      (step_q),
        .target    (tgt),
        .down      (down_q),
        .next      (nxt),
        .at_target (at_tgt)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cfg_valid) state_d = S_RUN;
            S_RUN: begin
                if (abort)
                    state_d = S_IDLE;
                else if (point_end && at_tgt && !loop_q)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            f_start_q <= '0;
            f_stop_q  <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            cnt_q     <= '0;
            loop_q    <= 1'b0;
            down_q    <= 1'b0;
            fword_q   <= '0;
            pword_q   <= '0;
            wave_q    <= '0;
`ifdef DDS_SWEEP_PINGPONG_EN
            tgt_q     <= '0;
`endif
        end else begin
            if (state_q == S_IDLE && cfg_valid) begin
                f_start_q <= cfg_f_start;
                f_stop_q  <= cfg_f_stop;
                step_q    <= cfg_f_step;
                dwell_q   <= cfg_dwell;
                cnt_q     <= cfg_dwell;
                loop_q    <= cfg_loop;
                down_q    <= (cfg_f_start > cfg_f_stop);
                fword_q   <= cfg_f_start;
                pword_q   <= cfg_pword;
                wave_q    <= cfg_wave;
`ifdef DDS_SWEEP_PINGPONG_EN
                tgt_q     <= cfg_f_stop;
`endif
            end else if (state_q == S_RUN && !abort) begin
                if (!point_end) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end else begin
                    cnt_q <= dwell_q;
                    if (!at_tgt) begin
                        fword_q <= nxt;
                    end else if (loop_q) begin
`ifdef DDS_SWEEP_PINGPONG_EN
                        tgt_q   <= rev_tgt;
                        down_q  <= ~down_q;
                        fword_q <= rev_at ? fword_q : rev_nxt;
`else
                        fword_q <= f_start_q;
`endif
                    end
                end
            end
        end
    end

    assign Fword         = fword_q;
    assign Pword         = pword_q;
    assign wave_type_out = wave_q;
    assign busy          = (state_q == S_RUN);
    assign sweep_done    = (state_q == S_DONE);
    assign cfg_ready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: directed sweeps, abort, loop.
// Loop expectations follow DDS_SWEEP_PINGPONG_EN when defined.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_f_start;
    logic [31:0] cfg_f_stop;
    logic [31:0] cfg_f_step;
    logic [23:0] cfg_dwell;
    logic [11:0] cfg_pword;
    logic [2:0]  cfg_wave;
    logic        cfg_loop;
    logic        abort;
    logic [31:0] Fword;
    logic [11:0] Pword;
    logic [2:0]  wave_type_out;
    logic        busy;
    logic        sweep_done;

    typedef struct packed {
        logic [31:0] f;
        logic [11:0] p;
        logic [2:0]  w;
        logic        b;
        logic        d;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [11:0] ep;
    logic [2:0]  ew;

    dds_sweep_ctrl #(.DWELL_W(24)) dut (
        .Clk           (clk),
        .Rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_f_start   (cfg_f_start),
        .cfg_f_stop    (cfg_f_stop),
        .cfg_f_step    (cfg_f_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_pword     (cfg_pword),
        .cfg_wave      (cfg_wave),
        .cfg_loop      (cfg_loop),
        .abort         (abort),
        .Fword         (Fword),
        .Pword         (Pword),
        .wave_type_out (wave_type_out),
        .busy          (busy),
        .sweep_done    (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pt(input logic [31:0] f, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{f: f, p: ep, w: ew, b: 1'b1, d: 1'b0};
            q.push_back(e);
        end
    endtask

    task automatic push_done(input logic [31:0] f);
        exp_t e;
        e = '{f: f, p: ep, w: ew, b: 1'b0, d: 1'b1};
        q.push_back(e);
    endtask

    // Monitor: every cycle the DUT is running or finishing is scored.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 || sweep_done === 1'b1) begin
                a = '{f: Fword, p: Pword, w: wave_type_out,
                      b: busy, d: sweep_done};
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got f=%0h b=%0b d=%0b expected none",
                             a.f, a.b, a.d);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        n_err++;
                        $display("FAIL sweep_pt: got f=%0h p=%0h w=%0h b=%0b d=%0b expected f=%0h p=%0h w=%0h b=%0b d=%0b",
                                 a.f, a.p, a.w, a.b, a.d,
                                 e.f, e.p, e.w, e.b, e.d);
                    end
                end
            end
        end
    end

    task automatic send_cfg(input logic [31:0] fs, input logic [31:0] fe,
                            input logic [31:0] st, input logic [23:0] dw,
                            input logic [11:0] pw, input logic [2:0] wv,
                            input logic lp);
        int t;
        t = 0;
        @(negedge clk);
        while (cfg_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got busy expected cfg_ready");
        end
        cfg_f_start = fs;
        cfg_f_stop  = fe;
        cfg_f_step  = st;
        cfg_dwell   = dw;
        cfg_pword   = pw;
        cfg_wave    = wv;
        cfg_loop    = lp;
        cfg_valid   = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid   = 1'b0;
        cfg_f_start = 32'hDEAD_BEEF;
        cfg_f_stop  = 32'h0BAD_F00D;
        cfg_f_step  = 32'h1;
        cfg_dwell   = 24'h7;
        cfg_pword   = 12'hFFF;
        cfg_wave    = 3'd7;
        cfg_loop    = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!(cfg_ready === 1'b1 && q.size() == 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0",
                     name, q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_f_start = '0;
        cfg_f_stop = '0;
        cfg_f_step = '0;
        cfg_dwell = '0;
        cfg_pword = '0;
        cfg_wave = '0;
        cfg_loop = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fword", Fword, 32'd0);
        chk("rst_pword", {20'd0, Pword}, 32'd0);
        chk("rst_wave", {29'd0, wave_type_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, sweep_done}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        rst = 1'b0;

        ep = 12'h123; ew = 3'd2;
        push_pt(1000, 3); push_pt(1100, 3);
        push_pt(1200, 3); push_pt(1300, 3);
        push_done(1300);
        send_cfg(1000, 1300, 100, 2, 12'h123, 3'd2, 1'b0);
        @(negedge clk);
        chk("ready_in_run", {31'd0, cfg_ready}, 32'd0);
        wait_done("up");

        ep = 12'h045; ew = 3'd1;
        push_pt(1000, 1); push_pt(1100, 1);
        push_pt(1200, 1); push_pt(1250, 1);
        push_done(1250);
        send_cfg(1000, 1250, 100, 0, 12'h045, 3'd1, 1'b0);
        wait_done("clamp");

        ep = 12'hABC; ew = 3'd3;
        push_pt(500, 2); push_pt(350, 2); push_pt(200, 2);
        push_done(200);
        send_cfg(500, 200, 150, 1, 12'hABC, 3'd3, 1'b0);
        wait_done("down");

        ep = 12'h001; ew = 3'd4;
        push_pt(32'hFFFF_FF00, 1); push_pt(32'hFFFF_FF80, 1);
        push_pt(32'hFFFF_FFFF, 1);
        push_done(32'hFFFF_FFFF);
        send_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 0,
                 12'h001, 3'd4, 1'b0);
        wait_done("nowrap");

        ep = 12'h777; ew = 3'd0;
        push_pt(700, 2);
        push_done(700);
        send_cfg(700, 900, 0, 1, 12'h777, 3'd0, 1'b0);
        wait_done("step0");

        ep = 12'h321; ew = 3'd2;
        push_pt(1000, 3); push_pt(1100, 1);
        send_cfg(1000, 1300, 100, 2, 12'h321, 3'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cfg_ready}, 32'd1);
        chk("abort_fword", Fword, 32'd1100);
        chk("abort_done", {31'd0, sweep_done}, 32'd0);
        chk("abort_pword", {20'd0, Pword}, 32'h321);
        wait_done("abort");

        ep = 12'h010; ew = 3'd1;
`ifdef DDS_SWEEP_PINGPONG_EN
        push_pt(0, 1); push_pt(100, 1); push_pt(200, 1);
        push_pt(100, 1); push_pt(0, 1); push_pt(100, 1);
`else
        push_pt(0, 1); push_pt(100, 1); push_pt(200, 1);
        push_pt(0, 1); push_pt(100, 1); push_pt(200, 1);
`endif
        send_cfg(0, 200, 100, 0, 12'h010, 3'd1, 1'b1);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("loop_busy", {31'd0, busy}, 32'd0);
`ifdef DDS_SWEEP_PINGPONG_EN
        chk("loop_fword", Fword, 32'd100);
`else
        chk("loop_fword", Fword, 32'd200);
`endif
        wait_done("loop");

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", {31'd0, cfg_ready}, 32'd1);
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
